// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word/address widths,
// wait-counter width and the responder FSM state encoding.
package dmem_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, registered read, write-first, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // Write on we; the read register returns the new data on a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MA-stage address interface. Accepts one load or
// store, counts WAIT_CYCLES wait states, then commits the store or returns
// the load data with a one-cycle rsp_valid pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is low only while waiting; stall is
// req_valid & ~req_ready. rsp_valid pulses once per accepted request and
// rsp_rdata/rsp_fault are meaningful only while it is high.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [WORD_W-1:0]  lat_wdata;
  logic               accept;
  logic               commit;
  logic               c_we;
  logic [ADDR_W-1:0]  c_addr;
  logic [WORD_W-1:0]  c_wdata;
  logic               c_fault;
  logic               ram_we;
  logic [WORD_W-1:0]  ram_rdata;
  logic               rsp_load;
  logic [WORD_W-1:0]  rdata_hold;

  assign req_ready = (state != ST_WAIT);
  assign stall     = req_valid & ~req_ready;
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid & req_ready;
  assign dbg_state = state;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (req_valid) begin
          cnt_nxt   = WAIT_INIT;
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= 1) state_nxt = ST_RESP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The commit happens on the edge entering RESP. With zero wait states that
  // is the acceptance edge itself, so the live request is used instead of
  // the latches (which only load on that same edge).
  always_comb begin
    commit  = (state_nxt == ST_RESP);
    c_we    = (state == ST_WAIT) ? lat_we    : req_we;
    c_addr  = (state == ST_WAIT) ? lat_addr  : req_addr;
    c_wdata = (state == ST_WAIT) ? lat_wdata : req_wdata;
    c_fault = ((c_addr >> DEPTH_LOG2) != '0);
    ram_we  = commit & c_we & ~c_fault;
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (c_addr[DEPTH_LOG2-1:0]),
    .wdata(c_wdata),
    .rdata(ram_rdata)
  );

  // Show fresh RAM data in the response cycle, otherwise the held value.
  assign rsp_rdata = (state == ST_RESP) ? (rsp_load ? ram_rdata : '0) : rdata_hold;

  // FSM, counter, request latches and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp_fault  <= 1'b0;
      rsp_load   <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_fault <= c_fault;
        rsp_load  <= ~c_we & ~c_fault;
      end
      if (state == ST_RESP) rdata_hold <= rsp_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different wait/depth
// settings, a table of single transactions plus hand-written sequences for
// back-to-back, streaming-with-stall and reset-abort behaviour.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int N = 4;
  // instance 0: WAIT=1 depth 12; 1: WAIT=0; 2: WAIT=3; 3: WAIT=1 depth 8
  localparam int WAITS [N] = '{1, 0, 3, 1};

  logic        clk;
  logic        rst;
  logic        req_valid [N];
  logic        req_we    [N];
  logic [11:0] req_addr  [N];
  logic [11:0] req_wdata [N];
  logic        req_ready [N];
  logic        stall     [N];
  logic        rsp_valid [N];
  logic [11:0] rsp_rdata [N];
  logic        rsp_fault [N];
  logic [1:0]  dbg_state [N];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_fault(rsp_fault[0]), .dbg_state(dbg_state[0]));

  dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_fault(rsp_fault[1]), .dbg_state(dbg_state[1]));

  dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .stall(stall[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_fault(rsp_fault[2]), .dbg_state(dbg_state[2]));

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_d8 (
    .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_we(req_we[3]),
    .req_addr(req_addr[3]), .req_wdata(req_wdata[3]), .req_ready(req_ready[3]),
    .stall(stall[3]), .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]),
    .rsp_fault(rsp_fault[3]), .dbg_state(dbg_state[3]));

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one transaction on instance idx, checking latency and response
  task automatic do_txn(input vec_t v);
    int n;
    int wt;
    wt = WAITS[v.idx];
    @(negedge clk);
    req_valid[v.idx] = 1'b1;
    req_we[v.idx]    = v.we;
    req_addr[v.idx]  = v.addr;
    req_wdata[v.idx] = v.wdata;
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    req_we[v.idx]    = 1'($urandom_range(0, 1));
    req_addr[v.idx]  = 12'($urandom_range(0, 4095));
    req_wdata[v.idx] = 12'($urandom_range(0, 4095));
    for (n = 1; n <= 40; n++) begin
      if (rsp_valid[v.idx]) break;
      check($sformatf("ready_low_in_wait[%0d]", v.idx), 32'(req_ready[v.idx]), 32'd0);
      @(negedge clk);
    end
    check($sformatf("latency[%0d] addr %h", v.idx, v.addr), 32'(n), 32'(wt + 1));
    check($sformatf("rdata[%0d] addr %h", v.idx, v.addr), 32'(rsp_rdata[v.idx]), 32'(v.exp_rdata));
    check($sformatf("fault[%0d] addr %h", v.idx, v.addr), 32'(rsp_fault[v.idx]), 32'(v.exp_fault));
  endtask

  task automatic add_vec(input int idx, input logic we, input logic [11:0] addr,
                         input logic [11:0] wdata, input logic [11:0] exp_rdata,
                         input logic exp_fault);
    vec_t v;
    v.idx = idx; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
    vecs.push_back(v);
  endtask

  initial begin
    logic [11:0] exp_q[$];
    logic [11:0] exp_d;

    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end

    // table of single transactions
    add_vec(0, 1'b1, 12'h010, 12'hABC, 12'h000, 1'b0);
    add_vec(0, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b0);
    add_vec(0, 1'b1, 12'h020, 12'h123, 12'h000, 1'b0);
    add_vec(0, 1'b0, 12'h020, 12'h000, 12'h123, 1'b0);
    add_vec(0, 1'b1, 12'hFFF, 12'h0F0, 12'h000, 1'b0);
    add_vec(0, 1'b0, 12'hFFF, 12'h000, 12'h0F0, 1'b0);
    add_vec(1, 1'b1, 12'h001, 12'h111, 12'h000, 1'b0);
    add_vec(1, 1'b1, 12'h002, 12'h222, 12'h000, 1'b0);
    add_vec(1, 1'b1, 12'h003, 12'h333, 12'h000, 1'b0);
    add_vec(2, 1'b1, 12'h040, 12'h3C3, 12'h000, 1'b0);
    add_vec(2, 1'b1, 12'h041, 12'h0C0, 12'h000, 1'b0);
    add_vec(3, 1'b1, 12'h000, 12'h456, 12'h000, 1'b0);
    add_vec(3, 1'b1, 12'h0FF, 12'h777, 12'h000, 1'b0);
    add_vec(3, 1'b1, 12'h100, 12'h5A5, 12'h000, 1'b1);
    add_vec(3, 1'b0, 12'h000, 12'h000, 12'h456, 1'b0);
    add_vec(3, 1'b0, 12'h0FF, 12'h000, 12'h777, 1'b0);
    add_vec(3, 1'b0, 12'h1FF, 12'h000, 12'h000, 1'b1);
    add_vec(3, 1'b0, 12'h100, 12'h000, 12'h000, 1'b1);

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("reset_stall[%0d]", i), 32'(stall[i]), 32'd0);
      check($sformatf("reset_rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("reset_rdata[%0d]", i), 32'(rsp_rdata[i]), 32'd0);
      check($sformatf("reset_fault[%0d]", i), 32'(rsp_fault[i]), 32'd0);
      check($sformatf("reset_state[%0d]", i), 32'(dbg_state[i]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready[0]), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid[0]), 32'd0);

    // table-driven pass
    foreach (vecs[k]) do_txn(vecs[k]);

    // back-to-back loads, zero wait states
    exp_q = '{12'h111, 12'h222, 12'h333};
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 12'h001;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      check($sformatf("b2b_stall_%0d", t), 32'(stall[1]), 32'd0);
      check($sformatf("b2b_rsp_valid_%0d", t), 32'(rsp_valid[1]), 32'd1);
      exp_d = exp_q.pop_front();
      check($sformatf("b2b_rdata_%0d", t), 32'(rsp_rdata[1]), 32'(exp_d));
      if (t == 3) req_valid[1] = 1'b0;
      else req_addr[1] = 12'(t + 1);
    end
    @(negedge clk);
    check("b2b_rsp_valid_end", 32'(rsp_valid[1]), 32'd0);
    check("b2b_rdata_hold", 32'(rsp_rdata[1]), 32'h333);

    // continuous requests with three wait states; address churn in WAIT
    exp_q = '{12'h3C3, 12'h0C0};
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 12'h040;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      check($sformatf("stream_rsp_valid_%0d", t), 32'(rsp_valid[2]), 32'((t % 4) == 0));
      check($sformatf("stream_stall_%0d", t), 32'(stall[2]), 32'((t % 4) != 0));
      if ((t % 4) == 0) begin
        exp_d = exp_q.pop_front();
        check($sformatf("stream_rdata_%0d", t), 32'(rsp_rdata[2]), 32'(exp_d));
      end
      case (t)
        1: req_addr[2] = 12'h7FF;
        3: req_addr[2] = 12'h041;
        5: req_addr[2] = 12'h000;
        8: req_valid[2] = 1'b0;
        default: ;
      endcase
    end

    // reset during the wait of a store: no response, no write
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 12'h020;
    req_wdata[0] = 12'hFFF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("abort_in_wait", 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("abort_no_rsp_%0d", t), 32'(rsp_valid[0]), 32'd0);
    end
    rst = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check($sformatf("abort_idle_rsp_%0d", t), 32'(rsp_valid[0]), 32'd0);
    end
    begin
      vec_t v;
      v.idx = 0; v.we = 1'b0; v.addr = 12'h020; v.wdata = 12'h000;
      v.exp_rdata = 12'h123; v.exp_fault = 1'b0;
      do_txn(v);
    end

    // final report
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
